// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//
// Responder side of the cache miss path. When a miss is pending, the block
// fetches one cache block from the pipelined main memory and writes it into
// the cache that missed. The block has WORDS_PER_BLOCK 16-bit words. The
// returned words go into the data array in order. The tag array is written
// in the same cycle as the last data word. The I-cache and the D-cache share
// one instance; arbitration between them happens upstream.
//
// Ports:
//   clk                rising-edge system clock
//   rst                asynchronous, active-low reset
//   miss_detected      level; a cache miss is pending
//   miss_address       byte address that missed (sampled when a fill starts)
//   memory_data        read data returned by memory
//   memory_data_valid  memory_data holds the next in-order returned word
//   fsm_busy           a fill is in progress
//   mem_req            read request to memory this cycle
//   memory_address     byte address of the current request (0 when idle)
//   write_data_array   write fill_data into the data array at fill_word_index
//   write_tag_array    write tag and set valid for the block
//   fill_word_index    word offset within the block being written
//   fill_data          word to write (the accepted memory_data)

module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic [15:0]                        memory_data,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_req,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic                               write_tag_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_index,
  output logic [15:0]                        fill_data
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;

  // Byte-offset bits inside a block: 2 bytes per word.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base, base_next;
  logic [CNT_W-1:0]  issue_cnt, issue_next;
  logic [CNT_W-1:0]  ret_cnt, ret_next;
  logic              issue;
  logic              accept;
  logic              last_word;

  // A response is only accepted for a request that is already outstanding.
  // A valid that arrives with no request outstanding is a protocol error
  // and is dropped, so a stray valid can never advance the return count.
  assign issue     = (state == FILL) && (issue_cnt < CNT_FULL);
  assign accept    = (state == FILL) && memory_data_valid && (ret_cnt < issue_cnt);
  assign last_word = (ret_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      state     <= state_next;
      base      <= base_next;
      issue_cnt <= issue_next;
      ret_cnt   <= ret_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    base_next  = base;
    issue_next = issue_cnt;
    ret_next   = ret_cnt;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_next = FILL;
          // Align to the block so the request offsets never carry out.
          base_next  = miss_address & ~OFF_MASK;
          issue_next = '0;
          ret_next   = '0;
        end
      end
      FILL: begin
        if (issue) begin
          issue_next = issue_cnt + CNT_W'(1);
        end
        if (accept) begin
          ret_next = ret_cnt + CNT_W'(1);
          if (last_word) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. The outputs come only from state, the counters and the
  // memory return. When the block leaves FILL, including on reset, every
  // output falls to zero.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word_index  = '0;
    fill_data        = '0;
    if (state == FILL) begin
      fsm_busy = 1'b1;
      if (issue) begin
        mem_req        = 1'b1;
        memory_address = base + ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
      end
      if (accept) begin
        write_data_array = 1'b1;
        write_tag_array  = last_word;
        fill_word_index  = ret_cnt[IDX_W-1:0];
        fill_data        = memory_data;
      end
    end
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Responder side of the cache miss path: consumes miss_detected/miss_address from the memory-cache interface and drives fsm_busy, write_data_array and write_tag_array back to it.
- Fetches one 16-byte block as eight 16-bit words from the pipelined multi-cycle main memory and sequences the data-array and tag-array writes into the missing cache.
- One instance is shared by the I-cache and the D-cache. Arbitration happens upstream, in the interface block.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of two.
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- miss_detected  in  1  level; a cache miss is pending.
- miss_address  in  16  byte address that missed; sampled only when a fill starts.
- memory_data  in  16  read data from memory.
- memory_data_valid  in  1  memory_data holds the next in-order returned word.
- fsm_busy  out  1  fill in progress.
- mem_req  out  1  read request to memory this cycle.
- memory_address  out  16  byte address of the current request.
- write_data_array  out  1  write fill_data into the data array at fill_word_index.
- write_tag_array  out  1  write tag and set valid for the block.
- fill_word_index  out  3  word offset within the block being written.
- fill_data  out  16  word to write; equals memory_data.

Behaviour:
- States: IDLE and FILL. Registers:
  - base (16b): low 4 bits always 0.
  - issue_cnt (4b): 0..8.
  - ret_cnt (4b): 0..8.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; base, issue_cnt and ret_cnt clear to 0.
  - All outputs 0 while reset is held and in the first IDLE cycle.
  - A reset mid-fill abandons the fill. No tag write occurs, and responses still in flight are ignored once back in IDLE.
- IDLE:
  - fsm_busy=0, mem_req=0, write_data_array=0, write_tag_array=0.
  - memory_data_valid is ignored.
  - If miss_detected=1 at a clock edge: base <= {miss_address[15:4],4'h0}; issue_cnt <= 0; ret_cnt <= 0; next state FILL.
- FILL:
  - fsm_busy=1 every FILL cycle.
  - miss_detected and miss_address are ignored; a second miss waits.
- Request issue:
  - mem_req=1 while issue_cnt<8.
  - memory_address = base + {issue_cnt[2:0],1'b0}, so requests go out back to back on eight consecutive cycles.
  - issue_cnt increments each cycle mem_req=1.
  - memory_address = 0 when mem_req=0.
- Return:
  - A response is accepted when memory_data_valid=1 and ret_cnt<issue_cnt.
  - On accept: write_data_array=1, fill_word_index=ret_cnt[2:0], fill_data=memory_data; ret_cnt increments.
  - Valid with ret_cnt>=issue_cnt is a protocol error and is dropped (no write).
  - Valid may arrive in the same cycle as a request issue.
- Completion:
  - The accept with ret_cnt==7 also asserts write_tag_array=1 in that same cycle.
  - Next state is IDLE, so fsm_busy drops the following cycle.
- Latency:
  - miss_detected sampled at edge N → FILL from cycle N+1; requests in cycles N+1..N+8.
  - With memory latency L (valid L cycles after request), data writes occur in cycles N+1+L..N+8+L and tag write in cycle N+8+L.
  - fsm_busy is high 8+L cycles (12 for L=4).
- Back-to-back: if miss_detected is still 1 in the first IDLE cycle, a new fill begins at that edge (one idle cycle minimum between fills).
- Address arithmetic is mod 2^16. Because base is block-aligned, the max address is base+14 and no carry out occurs.
- All outputs are decoded combinationally from state, counters and memory_data_valid. No output depends on miss_detected.

Test Plan:
1. Miss at 0x1234 with memory latency 4 → memory_address 0x1230,0x1232,…,0x123E on 8 consecutive cycles; write_data_array with index 0..7 carrying the returned words; write_tag_array only with index 7; fsm_busy high exactly 12 cycles.
2. miss_address 0xFFFA → base 0xFFF0, last request 0xFFFE, no wrap to 0x0000; tag write occurs.
3. Reset asserted after the 5th data write → all outputs 0 immediately (asynchronous); further valids are ignored and write_tag_array is never asserted; a new miss after release refetches from word 0.
4. memory_data_valid pulsed in IDLE, and valid pulsed in FILL before the first request → no write_data_array, counters unchanged.
5. miss_detected held high throughout → second fill starts after exactly one fsm_busy=0 cycle; miss_address change mid-fill has no effect on memory_address.
6. Irregular return spacing (gaps of 0–3 cycles between valids) → eight in-order writes with indices 0..7; fsm_busy holds until the 8th accept.
